// File: rtl/riscv_id.sv
// rtl/riscv_id.sv - RV32 decode stage, register file and ID/EX pipeline register
module riscv_id #(
    parameter int XLEN           = 32,
    parameter bit STALL_ON_EXMEM = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_id_pc,
    input  logic [31:0]     if_id_instr,
    input  logic            if_id_valid,
    input  logic            branch_taken,
    input  logic [4:0]      ex_mem_rd,
    input  logic            ex_mem_reg_write,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_wdata,
    output logic            id_stall,
    output logic [XLEN-1:0] id_ex_pc,
    output logic [XLEN-1:0] id_ex_rs1,
    output logic [XLEN-1:0] id_ex_rs2,
    output logic [XLEN-1:0] id_ex_imm,
    output logic [4:0]      id_ex_rd,
    output logic            id_ex_is_load,
    output logic            id_ex_is_store,
    output logic            id_ex_alu_src_imm,
    output logic            id_ex_reg_write,
    output logic            id_ex_valid,
    output logic [3:0]      id_ex_alu_op,
    output logic [1:0]      id_ex_wb_sel,
    output logic [2:0]      id_ex_funct3,
    output logic [6:0]      id_ex_funct7,
    output logic            illegal_instr
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            is_load;
        logic            is_store;
        logic            alu_src_imm;
        logic            reg_write;
        logic            valid;
        logic [3:0]      alu_op;
        logic [1:0]      wb_sel;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
    } id_ex_t;

    id_ex_t ex_d, ex_q;
    logic   illegal_d, illegal_q;

    logic [XLEN-1:0] rf_q [32];

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1_a, rs2_a, rd_a;
    assign opcode = if_id_instr[6:0];
    assign funct3 = if_id_instr[14:12];
    assign funct7 = if_id_instr[31:25];
    assign rs1_a  = if_id_instr[19:15];
    assign rs2_a  = if_id_instr[24:20];
    assign rd_a   = if_id_instr[11:7];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u;
    assign imm_i = {{20{if_id_instr[31]}}, if_id_instr[31:20]};
    assign imm_s = {{20{if_id_instr[31]}}, if_id_instr[31:25], if_id_instr[11:7]};
    assign imm_b = {{19{if_id_instr[31]}}, if_id_instr[31], if_id_instr[7],
                    if_id_instr[30:25], if_id_instr[11:8], 1'b0};
    assign imm_u = {if_id_instr[31:12], 12'b0};

    // Register file write port; x0 is never stored
    always_ff @(posedge clk) begin
        if (wb_we && wb_rd != 5'd0) rf_q[wb_rd] <= wb_wdata;
    end

    // Read ports with write-through so a same-cycle WB value is seen by ID
    logic [XLEN-1:0] rs1_val, rs2_val;
    assign rs1_val = (rs1_a == 5'd0) ? '0 : (wb_we && wb_rd == rs1_a) ? wb_wdata : rf_q[rs1_a];
    assign rs2_val = (rs2_a == 5'd0) ? '0 : (wb_we && wb_rd == rs2_a) ? wb_wdata : rf_q[rs2_a];

    logic            dec_legal, dec_uses1, dec_uses2, dec_has_rd, dec_src_imm;
    logic            dec_is_load, dec_is_store, dec_zero_rs1;
    logic [1:0]      dec_wb_sel;
    logic [3:0]      dec_alu_op;
    logic [XLEN-1:0] dec_imm;

    // Instruction decode: control fields, operand usage and legality
    always_comb begin
        dec_legal    = 1'b0;
        dec_uses1    = 1'b0;
        dec_uses2    = 1'b0;
        dec_has_rd   = 1'b0;
        dec_src_imm  = 1'b0;
        dec_is_load  = 1'b0;
        dec_is_store = 1'b0;
        dec_zero_rs1 = 1'b0;
        dec_wb_sel   = 2'd0;
        dec_alu_op   = 4'd0;
        dec_imm      = '0;
        case (opcode)
            OPC_OP: begin
                dec_uses1  = 1'b1;
                dec_uses2  = 1'b1;
                dec_has_rd = 1'b1;
                dec_legal  = 1'b1;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: dec_alu_op = 4'd0;
                    {7'b0000000, 3'b111}: dec_alu_op = 4'd1;
                    {7'b0000000, 3'b110}: dec_alu_op = 4'd2;
                    {7'b0000000, 3'b100}: dec_alu_op = 4'd3;
                    {7'b0000000, 3'b001}: dec_alu_op = 4'd4;
                    {7'b0000000, 3'b101}: dec_alu_op = 4'd5;
                    {7'b0100000, 3'b000}: dec_alu_op = 4'd6;
                    {7'b0000001, 3'b000}: dec_alu_op = 4'd10;
                    default:              dec_legal  = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                dec_uses1   = 1'b1;
                dec_has_rd  = 1'b1;
                dec_src_imm = 1'b1;
                dec_imm     = imm_i;
                dec_legal   = 1'b1;
                case (funct3)
                    3'b000:  dec_alu_op = 4'd0;
                    3'b111:  dec_alu_op = 4'd1;
                    3'b110:  dec_alu_op = 4'd2;
                    3'b100:  dec_alu_op = 4'd3;
                    3'b001: begin
                        dec_alu_op = 4'd4;
                        dec_legal  = (funct7 == 7'b0000000);
                    end
                    3'b101: begin
                        dec_alu_op = 4'd5;
                        dec_legal  = (funct7 == 7'b0000000);
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                dec_uses1   = 1'b1;
                dec_has_rd  = 1'b1;
                dec_src_imm = 1'b1;
                dec_is_load = 1'b1;
                dec_wb_sel  = 2'd1;
                dec_imm     = imm_i;
                dec_legal   = (funct3 == 3'b010);
            end
            OPC_STORE: begin
                dec_uses1    = 1'b1;
                dec_uses2    = 1'b1;
                dec_src_imm  = 1'b1;
                dec_is_store = 1'b1;
                dec_imm      = imm_s;
                dec_legal    = (funct3 == 3'b010);
            end
            OPC_BRANCH: begin
                dec_uses1  = 1'b1;
                dec_uses2  = 1'b1;
                dec_alu_op = 4'd7;
                dec_imm    = imm_b;
                dec_legal  = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                             (funct3 == 3'b100) || (funct3 == 3'b101);
            end
            OPC_LUI: begin
                dec_has_rd   = 1'b1;
                dec_src_imm  = 1'b1;
                dec_zero_rs1 = 1'b1;
                dec_imm      = imm_u;
                dec_legal    = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // RAW hazard against producers still in flight; no forwarding exists downstream
    logic hz_ex, hz_mem;
    assign hz_ex  = ex_q.valid && ex_q.reg_write && (ex_q.rd != 5'd0) &&
                    ((dec_uses1 && rs1_a == ex_q.rd) || (dec_uses2 && rs2_a == ex_q.rd));
    assign hz_mem = STALL_ON_EXMEM && ex_mem_reg_write && (ex_mem_rd != 5'd0) &&
                    ((dec_uses1 && rs1_a == ex_mem_rd) || (dec_uses2 && rs2_a == ex_mem_rd));
    assign id_stall = if_id_valid && (hz_ex || hz_mem) && !branch_taken;

    // Next ID/EX contents: flush and stall both issue an all-zero bubble
    always_comb begin
        ex_d      = '0;
        illegal_d = 1'b0;
        if (if_id_valid && !branch_taken && !id_stall) begin
            if (dec_legal) begin
                ex_d.pc          = if_id_pc;
                ex_d.rs1         = dec_zero_rs1 ? '0 : rs1_val;
                ex_d.rs2         = rs2_val;
                ex_d.imm         = dec_imm;
                ex_d.rd          = dec_has_rd ? rd_a : 5'd0;
                ex_d.is_load     = dec_is_load;
                ex_d.is_store    = dec_is_store;
                ex_d.alu_src_imm = dec_src_imm;
                ex_d.reg_write   = dec_has_rd && (rd_a != 5'd0);
                ex_d.valid       = 1'b1;
                ex_d.alu_op      = dec_alu_op;
                ex_d.wb_sel      = dec_wb_sel;
                ex_d.funct3      = funct3;
                ex_d.funct7      = funct7;
            end else begin
                illegal_d = 1'b1;
            end
        end
    end

    // ID/EX pipeline register and illegal-instruction pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            illegal_q <= illegal_d;
        end
    end

    assign id_ex_pc          = ex_q.pc;
    assign id_ex_rs1         = ex_q.rs1;
    assign id_ex_rs2         = ex_q.rs2;
    assign id_ex_imm         = ex_q.imm;
    assign id_ex_rd          = ex_q.rd;
    assign id_ex_is_load     = ex_q.is_load;
    assign id_ex_is_store    = ex_q.is_store;
    assign id_ex_alu_src_imm = ex_q.alu_src_imm;
    assign id_ex_reg_write   = ex_q.reg_write;
    assign id_ex_valid       = ex_q.valid;
    assign id_ex_alu_op      = ex_q.alu_op;
    assign id_ex_wb_sel      = ex_q.wb_sel;
    assign id_ex_funct3      = ex_q.funct3;
    assign id_ex_funct7      = ex_q.funct7;
    assign illegal_instr     = illegal_q;
endmodule
